grad_step_engine: RTL and testbench
===================================

# grad_step_engine

Parametrised N-dimensional finite-difference gradient-step engine for the fixed-point gradient-descent datapath. Given a point x (N_DIM signed Q-format coordinates), it drives one shared, time-multiplexed function evaluator through a request/acknowledge port. It forms each partial derivative by finite difference and outputs the saturated step diff_i = LR_i * grad_i per dimension plus f(x). It sits between the descent controller (which subtracts the diffs from x) and the function evaluator. It replaces N+1 parallel evaluators with one.

## Interface
- N_DIM, 4: number of coordinates.
- DATA_W, 16: coordinate and diff width, signed.
- FRAC_W, 8: fractional bits of coordinates, values, and learning rates.
- VAL_W, 32: function-value width, signed, same FRAC_W.
- H_SHIFT, 1: step h = 2^H_SHIFT LSBs. Requires H_SHIFT < FRAC_W.
- LR, {N_DIM{32'h0000_0010}}: packed per-dimension learning rates, VAL_W bits each, Q(VAL_W-FRAC_W).FRAC_W. Default is 0.0625. Dimension 0 occupies the LSBs.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin step; sampled only in IDLE.
- x_in  in  N_DIM*DATA_W  point; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; outputs valid from this cycle until next accepted start.
- value_out  out  VAL_W  f(x).
- diff_out  out  N_DIM*DATA_W  saturated steps.
- sat_out  out  N_DIM  per-dimension diff saturation flags.
- overflow  out  1  OR of evaluator overflow and perturbation clamp, for this step.
- eval_req  out  1  evaluation request.
- eval_x  out  N_DIM*DATA_W  point to evaluate.
- eval_ack  in  1  evaluator result valid.
- eval_z  in  VAL_W  result.
- eval_ovf  in  1  evaluator overflow for this result.

## Operation
- States: IDLE, BASE, PERT, STEP, DONE.
- IDLE: on start=1, capture x_in into x_buf, clear overflow and sat_out, set dim=0, and go to BASE.
- BASE: drive eval_req=1 with eval_x=x_buf. On eval_ack, store z_base, OR eval_ovf into overflow, and go to PERT.
- PERT: drive eval_req=1 with eval_x = x_buf, where coordinate dim is replaced by x_dim - h. On eval_ack, store grad = (z_base - eval_z) <<< (FRAC_W - H_SHIFT), held at VAL_W+FRAC_W+1 bits with no overflow. Then go to STEP.
- STEP: compute p = (grad * LR_dim) >>> FRAC_W, arithmetic shift (rounds toward -inf).
  - Clamp p to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Write the result to diff slot dim, and set sat_out[dim] if clamped.
  - If dim = N_DIM-1, go to DONE. Otherwise increment dim and go to PERT.
- DONE: update value_out=z_base and diff_out, pulse done, and go to IDLE.
- Perturbation boundary: if x_dim - h < -2^(DATA_W-1), the perturbed coordinate clamps to the minimum and overflow is set. The gradient is still computed as above.
- start while busy is ignored. eval_ack while eval_req=0 is ignored.

## Timing
- eval_req rises the cycle after entering BASE/PERT.
- eval_req and eval_x are held stable until the eval_ack cycle, then eval_req drops the next cycle.
- eval_z and eval_ovf are sampled only on the eval_ack cycle. The minimum ack latency is 1 cycle after eval_req rises.
- With ack latency L, step latency (start accepted to done) = (N_DIM+1)*(L+1) + N_DIM + 1 cycles.
- Reset values: busy=0, done=0, eval_req=0, eval_x=0, value_out=0, diff_out=0, sat_out=0, overflow=0, state=IDLE.
- Reset mid-operation forces IDLE at the next edge and drops eval_req. A pending evaluator result is discarded.
- Outputs other than done change only on the DONE cycle and on reset.

## Configuration
- GRAD_CENTRAL_DIFF_EN defined: PERT evaluates both x+h and x-h, as two handshakes in that order.
  - grad = (z_plus - z_minus) <<< (FRAC_W - H_SHIFT - 1).
  - x+h above the maximum clamps and sets overflow.
  - Latency becomes (2*N_DIM+1)*(L+1) + N_DIM + 1.
- Undefined: backward difference as above, with N_DIM+1 evaluations.

## Structure
- Package grad_pkg holds:
  - the state enum;
  - the GRAD_W, PROD_W localparam derivations;
  - the saturate-to-DATA_W function;
  - the packed-slot index helper.
- Sub-module grad_diff_sat holds the combinational multiply, shift, and clamp, with one instance shared across dimensions via the dim mux.

## Test plan
- Bench evaluator model is f = Σ (x_i*x_i)>>>8, with L=3. Stimulus x0=0x0100, others 0, defaults.
  - Required: value_out=0x100, diff0=0x0020, diff1..3=0, sat_out=0, done at cycle 25.
- GRAD_CENTRAL_DIFF_EN, same stimulus -> diff0=0x0020, other diffs 0, done at cycle 41.
- Forced evaluator: z_base=0x7FFF0000, perturbed z=0 -> all diff=0x7FFF, sat_out=4'hF. Swap the two (base 0, perturbed 0x00010000) -> diff=0x8000 each, sat_out=4'hF.
- x2=0x8000 -> perturbed eval_x coordinate 2 = 0x8000, overflow=1. Separately, eval_ovf=1 on one ack -> overflow=1.
- Handshake: ack latency 1 versus 7, start pulsed while busy, eval_ack while eval_req is low. Required: identical results, eval_x stable while eval_req is high, second start ignored.
- rst_n low for one cycle during PERT of dim 2 -> eval_req=0 and all outputs zero next cycle. A subsequent start completes normally.

Source files
------------

// File: rtl/grad_pkg.sv
// Shared types and helpers for the finite-difference gradient-step engine.
package grad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_PERT,
    S_STEP,
    S_DONE
  } state_t;

  // Working width wide enough for any shifted product at legal parameter sizes.
  localparam int SAT_IN_W = 128;

  // Gradient register: difference of two VAL_W values, pre-shifted by up to FRAC_W.
  function automatic int grad_w_of(input int val_w, input int frac_w);
    return val_w + frac_w + 1;
  endfunction

  function automatic int prod_w_of(input int grad_w, input int val_w);
    return grad_w + val_w;
  endfunction

  // Clamp a signed value to the range of a data_w-bit signed number.
  function automatic logic signed [SAT_IN_W-1:0] sat_to_w(input logic signed [SAT_IN_W-1:0] v,
                                                          input int data_w);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (SAT_IN_W'(1) << (data_w - 1)) - SAT_IN_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // Low bit of packed slot `dim` in a vector of `w`-bit slots.
  function automatic int slot_lo(input int dim, input int w);
    return dim * w;
  endfunction

endpackage

// File: rtl/grad_diff_sat.sv
// Combinational step datapath: diff = sat((grad * lr) >>> FRAC_W) to DATA_W bits.
module grad_diff_sat
  import grad_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int VAL_W  = 32,
  parameter int GRAD_W = 41
) (
  input  logic [GRAD_W-1:0] grad,
  input  logic [VAL_W-1:0]  lr,
  output logic [DATA_W-1:0] diff,
  output logic              sat
);

  localparam int PROD_W = prod_w_of(GRAD_W, VAL_W);

  logic signed [PROD_W-1:0]   prod;
  logic signed [SAT_IN_W-1:0] shifted;
  logic signed [SAT_IN_W-1:0] clamped;

  always_comb begin
    prod    = $signed(grad) * $signed(lr);
    // Arithmetic shift rounds toward -inf, matching the descent controller's model.
    shifted = $signed({{(SAT_IN_W-PROD_W){prod[PROD_W-1]}}, prod}) >>> FRAC_W;
    clamped = sat_to_w(shifted, DATA_W);
    diff    = clamped[DATA_W-1:0];
    sat     = (clamped != shifted);
  end

endmodule

// File: rtl/grad_step_engine.sv
// Finite-difference gradient-step engine driving one shared evaluator.
// Define GRAD_CENTRAL_DIFF_EN for central differences (two evaluations per dimension).
module grad_step_engine
  import grad_pkg::*;
#(
  parameter int N_DIM   = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int VAL_W   = 32,
  parameter int H_SHIFT = 1,
  parameter logic [N_DIM*VAL_W-1:0] LR = {N_DIM{32'h0000_0010}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_DIM*DATA_W-1:0] x_in,
  output logic                    busy,
  output logic                    done,
  output logic [VAL_W-1:0]        value_out,
  output logic [N_DIM*DATA_W-1:0] diff_out,
  output logic [N_DIM-1:0]        sat_out,
  output logic                    overflow,
  output logic                    eval_req,
  output logic [N_DIM*DATA_W-1:0] eval_x,
  input  logic                    eval_ack,
  input  logic [VAL_W-1:0]        eval_z,
  input  logic                    eval_ovf
);

  localparam int GRAD_W = grad_w_of(VAL_W, FRAC_W);
  localparam int DIM_W  = (N_DIM > 1) ? $clog2(N_DIM) : 1;
`ifdef GRAD_CENTRAL_DIFF_EN
  localparam bit CENTRAL = 1'b1;
`else
  localparam bit CENTRAL = 1'b0;
`endif
  localparam int               G_SHIFT  = CENTRAL ? (FRAC_W - H_SHIFT - 1) : (FRAC_W - H_SHIFT);
  localparam logic [DATA_W:0]  H_VAL    = (DATA_W+1)'(1) << H_SHIFT;
  localparam logic [DIM_W-1:0] LAST_DIM = DIM_W'(N_DIM - 1);

  state_t                  state, state_next;
  logic [DIM_W-1:0]        dim;
  logic                    phase;      // central mode: 0 = x+h pending, 1 = x-h pending
  logic [N_DIM*DATA_W-1:0] x_buf;
  logic [VAL_W-1:0]        z_base, z_plus;
  logic [GRAD_W-1:0]       grad;
  logic                    ovf_acc;
  logic [N_DIM-1:0]        sat_acc;
  logic [N_DIM*DATA_W-1:0] diff_buf;

  logic [DATA_W-1:0]       coord, pert_coord;
  logic [DATA_W:0]         coord_ext, pert_ext;
  logic                    plus_sel, pert_clamp;
  logic [VAL_W-1:0]        z_hi;
  logic [GRAD_W-1:0]       grad_next;
  logic [VAL_W-1:0]        lr_sel;
  logic [DATA_W-1:0]       step_diff;
  logic                    step_sat;
  logic [N_DIM*DATA_W-1:0] diff_next;
  logic [N_DIM-1:0]        sat_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    coord      = x_buf[slot_lo(int'(dim), DATA_W) +: DATA_W];
    coord_ext  = {coord[DATA_W-1], coord};
    plus_sel   = CENTRAL && !phase;
    pert_ext   = plus_sel ? (coord_ext + H_VAL) : (coord_ext - H_VAL);
    pert_clamp = (pert_ext[DATA_W] != pert_ext[DATA_W-1]);
    pert_coord = pert_ext[DATA_W-1:0];
    if (pert_clamp)
      pert_coord = plus_sel ? {1'b0, {(DATA_W-1){1'b1}}} : {1'b1, {(DATA_W-1){1'b0}}};

    z_hi      = CENTRAL ? z_plus : z_base;
    grad_next = ({{(GRAD_W-VAL_W){z_hi[VAL_W-1]}}, z_hi}
               - {{(GRAD_W-VAL_W){eval_z[VAL_W-1]}}, eval_z}) << G_SHIFT;

    lr_sel    = LR[slot_lo(int'(dim), VAL_W) +: VAL_W];
    diff_next = diff_buf;
    diff_next[slot_lo(int'(dim), DATA_W) +: DATA_W] = step_diff;
    sat_next  = sat_acc;
    sat_next[dim] = step_sat;
  end

  grad_diff_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .VAL_W  (VAL_W),
    .GRAD_W (GRAD_W)
  ) u_diff_sat (
    .grad (grad),
    .lr   (lr_sel),
    .diff (step_diff),
    .sat  (step_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_BASE;
      S_BASE:  if (eval_ack) state_next = S_PERT;
      S_PERT:  if (eval_ack && (!CENTRAL || phase)) state_next = S_STEP;
      S_STEP:  state_next = (dim == LAST_DIM) ? S_DONE : S_PERT;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    eval_req = (state == S_BASE) || (state == S_PERT);
    eval_x   = x_buf;
    if (state == S_PERT) eval_x[slot_lo(int'(dim), DATA_W) +: DATA_W] = pert_coord;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Results load on the edge into DONE so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dim       <= '0;
      phase     <= 1'b0;
      x_buf     <= '0;
      z_base    <= '0;
      z_plus    <= '0;
      grad      <= '0;
      ovf_acc   <= 1'b0;
      sat_acc   <= '0;
      diff_buf  <= '0;
      value_out <= '0;
      diff_out  <= '0;
      sat_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          x_buf   <= x_in;
          ovf_acc <= 1'b0;
          sat_acc <= '0;
          dim     <= '0;
          phase   <= 1'b0;
        end
        S_BASE: if (eval_ack) begin
          z_base  <= eval_z;
          ovf_acc <= ovf_acc | eval_ovf;
        end
        S_PERT: if (eval_ack) begin
          ovf_acc <= ovf_acc | eval_ovf | pert_clamp;
          if (CENTRAL && !phase) begin
            z_plus <= eval_z;
            phase  <= 1'b1;
          end else begin
            grad  <= grad_next;
            phase <= 1'b0;
          end
        end
        S_STEP: begin
          diff_buf <= diff_next;
          sat_acc  <= sat_next;
          if (dim == LAST_DIM) begin
            value_out <= z_base;
            diff_out  <= diff_next;
            sat_out   <= sat_next;
            overflow  <= ovf_acc;
          end else begin
            dim <= dim + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grad_step_engine.sv
// Directed, table-driven bench for grad_step_engine with a behavioural evaluator.
`timescale 1ns/1ps
module tb_grad_step_engine;

`ifdef GRAD_CENTRAL_DIFF_EN
  localparam int NEV      = 9;
  localparam int CLAMP_TX = 6;
  localparam int RST_TX   = 5;
`else
  localparam int NEV      = 5;
  localparam int CLAMP_TX = 3;
  localparam int RST_TX   = 3;
`endif

  logic        clk, rst_n, start;
  logic [63:0] x_in;
  logic        busy, done, overflow, eval_req, eval_ack, eval_ovf;
  logic [31:0] value_out, eval_z;
  logic [63:0] diff_out, eval_x;
  logic [3:0]  sat_out;

  grad_step_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
    .busy(busy), .done(done), .value_out(value_out), .diff_out(diff_out),
    .sat_out(sat_out), .overflow(overflow), .eval_req(eval_req), .eval_x(eval_x),
    .eval_ack(eval_ack), .eval_z(eval_z), .eval_ovf(eval_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Evaluator configuration and bookkeeping
  int          lat_cfg    = 3;
  bit          force_mode = 0;
  logic [31:0] zb_f = 0, zp_f = 0;
  int          ovf_tx     = -1;
  bit          spur       = 0;
  logic [63:0] x_cur      = 0;
  int          tx_n       = 0;
  int          stab_err   = 0;
  logic [63:0] tx_log [16];

  function automatic logic [31:0] f_model(input logic [63:0] x);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] c;
      c = x[i*16 +: 16];
      s += (int'(c) * int'(c)) >>> 8;
    end
    return s;
  endfunction

  function automatic bit is_plus(input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 4; i++)
      if ($signed(a[i*16 +: 16]) > $signed(b[i*16 +: 16])) return 1'b1;
    return 1'b0;
  endfunction

  // Ack arrives lat_cfg cycles after the cycle eval_req is first seen high.
  initial begin
    int          cnt;
    logic [63:0] tx_x;
    cnt = 0; tx_x = '0;
    eval_ack = 1'b0; eval_z = '0; eval_ovf = 1'b0;
    forever begin
      @(negedge clk);
      eval_ack = 1'b0; eval_ovf = 1'b0; eval_z = 32'hDEAD_BEEF;
      if (!eval_req) begin
        cnt = 0;
        if (spur) begin
          eval_ack = 1'b1; eval_z = 32'h1234_5678; eval_ovf = 1'b1;
        end
      end else begin
        cnt++;
        if (cnt == 1) begin
          tx_x = eval_x;
          if (tx_n < 16) tx_log[tx_n] = eval_x;
          tx_n++;
        end else if (eval_x !== tx_x) begin
          stab_err++;
        end
        if (cnt == lat_cfg + 1) begin
          eval_ack = 1'b1;
          eval_ovf = ((tx_n - 1) == ovf_tx);
          if (force_mode)
            eval_z = (eval_x == x_cur || is_plus(eval_x, x_cur)) ? zb_f : zp_f;
          else
            eval_z = f_model(eval_x);
          cnt = 0;
        end
      end
    end
  end

  task automatic do_step(input logic [63:0] x, input bit again,
                         output int cyc, output bit seen, output logic b1);
    x_cur = x; tx_n = 0; stab_err = 0;
    @(negedge clk);
    x_in = x; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; seen = 1'b0; b1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i == 0) b1 = busy;
      start = again && (i == 3);
      if (again && i == 3) x_in = 64'hA5A5_5A5A_1234_4321;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [63:0] x;
    int          lat;
    bit          frc;
    logic [31:0] zb, zp;
    int          ovf_at;
    bit          again;
    bit          spur;
    logic [31:0] ev;
    logic [63:0] ed;
    logic [3:0]  es;
    bit          eo;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    int          cyc;
    bit          seen, found;
    logic        b1;
    logic [63:0] d_clamp;
`ifdef GRAD_CENTRAL_DIFF_EN
    d_clamp = 64'h0000_F800_0000_0000;
`else
    d_clamp = 64'h0;
`endif
    vecs[0] = '{64'h0000_0000_0000_0100, 3, 0, 0, 0, -1, 0, 0, 32'h100, 64'h20, 4'h0, 0};
    vecs[1] = '{64'h0000_0000_0000_0100, 1, 0, 0, 0, -1, 0, 0, 32'h100, 64'h20, 4'h0, 0};
    vecs[2] = '{64'h0000_0000_0000_0100, 7, 0, 0, 0, -1, 1, 0, 32'h100, 64'h20, 4'h0, 0};
    vecs[3] = '{64'h0000_0000_0000_0100, 2, 1, 32'h7FFF_0000, 32'h0, -1, 0, 0,
                32'h7FFF_0000, 64'h7FFF_7FFF_7FFF_7FFF, 4'hF, 0};
    vecs[4] = '{64'h0000_0000_0000_0100, 2, 1, 32'h0, 32'h0001_0000, -1, 0, 0,
                32'h0, 64'h8000_8000_8000_8000, 4'hF, 0};
    vecs[5] = '{64'h0000_8000_0000_0000, 3, 0, 0, 0, -1, 0, 0, 32'h0040_0000, d_clamp, 4'h0, 1};
    vecs[6] = '{64'h0000_0000_0000_0100, 3, 0, 0, 0, 2, 0, 0, 32'h100, 64'h20, 4'h0, 1};
    vecs[7] = '{64'h0000_0000_FF00_0000, 4, 0, 0, 0, -1, 0, 1, 32'h100, 64'h0000_0000_FFE0_0000, 4'h0, 0};
    vecs[8] = '{64'h0080_0000_0000_0200, 2, 0, 0, 0, -1, 0, 0, 32'h440, 64'h0010_0000_0000_0040, 4'h0, 0};

    rst_n = 1'b0; start = 1'b0; x_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_eval_req", eval_req, 0);
    check("rst_eval_x", eval_x, 0);
    check("rst_value", value_out, 0);
    check("rst_diff", diff_out, 0);
    check("rst_sat", sat_out, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      lat_cfg = vecs[i].lat; force_mode = vecs[i].frc;
      zb_f = vecs[i].zb; zp_f = vecs[i].zp;
      ovf_tx = vecs[i].ovf_at; spur = vecs[i].spur;
      do_step(vecs[i].x, vecs[i].again, cyc, seen, b1);
      spur = 1'b0;
      check($sformatf("v%0d_done_seen", i), seen, 1);
      check($sformatf("v%0d_latency", i), cyc, NEV * (vecs[i].lat + 1) + 5);
      check($sformatf("v%0d_busy", i), b1, 1);
      check($sformatf("v%0d_value", i), value_out, vecs[i].ev);
      check($sformatf("v%0d_diff", i), diff_out, vecs[i].ed);
      check($sformatf("v%0d_sat", i), sat_out, vecs[i].es);
      check($sformatf("v%0d_overflow", i), overflow, vecs[i].eo);
      check($sformatf("v%0d_eval_x_stable", i), stab_err, 0);
      if (vecs[i].x == 64'h0000_8000_0000_0000)
        check($sformatf("v%0d_clamped_coord", i), tx_log[CLAMP_TX][47:32], 16'h8000);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Reset while the engine is evaluating dimension 2.
    lat_cfg = 3; force_mode = 0; ovf_tx = -1;
    x_cur = 64'h0000_0000_0000_0100; tx_n = 0;
    @(negedge clk);
    x_in = 64'h0000_0000_0000_0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eval_req && tx_n == RST_TX + 1) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_rst_reached_dim2", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_eval_req", eval_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_eval_x", eval_x, 0);
    check("mid_rst_value", value_out, 0);
    check("mid_rst_diff", diff_out, 0);
    check("mid_rst_sat", sat_out, 0);
    check("mid_rst_overflow", overflow, 0);
    rst_n = 1'b1;

    lat_cfg = 2;
    do_step(64'h0080_0000_0000_0200, 1'b0, cyc, seen, b1);
    check("post_rst_done_seen", seen, 1);
    check("post_rst_latency", cyc, NEV * 3 + 5);
    check("post_rst_value", value_out, 32'h440);
    check("post_rst_diff", diff_out, 64'h0010_0000_0000_0040);
    check("post_rst_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
